// File: rtl/vc_control.sv
// vc_control: sequencing FSM for the 8-entry fully associative victim cache datapath.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   up_read/up_write/up_dirty  L2-side lookup / eviction request, held until up_resp
//   up_resp, up_hit            one-cycle completion pulse and read-hit flag
//   pmem_read/pmem_write       memory strobes held until pmem_resp
//   VC_hit, VC_hit_dirty, hit_way, LRU_out, dirty_bits   datapath lookup results
//   load_VC, load_VC_dirty, load_LRU, L2_read, VC_dirty_bit, VC_write, load_index,
//   read_index, write_index, wb_index_in                 datapath strobes and indices
//   cnt_clear, hit_count, miss_count                     saturating read hit/miss counters
module vc_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_read,
    input  logic             up_write,
    input  logic             up_dirty,
    output logic             up_resp,
    output logic             up_hit,
    output logic             pmem_read,
    output logic             pmem_write,
    input  logic             pmem_resp,
    input  logic             VC_hit,
    input  logic             VC_hit_dirty,
    input  logic [2:0]       hit_way,
    input  logic [23:0]      LRU_out,
    input  logic [7:0]       dirty_bits,
    output logic             load_VC,
    output logic             load_VC_dirty,
    output logic             load_LRU,
    output logic             L2_read,
    output logic             VC_dirty_bit,
    output logic             VC_write,
    output logic             load_index,
    output logic [2:0]       read_index,
    output logic [2:0]       write_index,
    output logic [2:0]       wb_index_in,
    input  logic             cnt_clear,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);
    typedef enum logic [2:0] {IDLE, LOOKUP, RD_MEM, WB_ADDR, WB_MEM, FILL, RESP} state_t;

    state_t     state;
    logic [2:0] v;
    logic       hit_r;
    logic       lk, rd_hit, rd_miss, wr_hit, fill;

    assign lk      = state == LOOKUP;
    assign rd_hit  = lk & up_read & VC_hit;
    assign rd_miss = lk & up_read & ~VC_hit;
    assign wr_hit  = lk & up_write & VC_hit;
    assign fill    = state == FILL;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            v          <= '0;
            hit_r      <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            case (state)
                IDLE:    if (up_read | up_write) state <= LOOKUP;
                LOOKUP: begin
                    hit_r <= rd_hit;
                    if (up_read) state <= VC_hit ? RESP : RD_MEM;
                    else if (up_write && VC_hit) state <= RESP;
                    else if (up_write) begin
                        // victim way is latched so later LRU updates cannot move it
                        v     <= LRU_out[2:0];
                        state <= dirty_bits[LRU_out[2:0]] ? WB_ADDR : FILL;
                    end else state <= IDLE;
                end
                RD_MEM:  if (pmem_resp) state <= RESP;
                WB_ADDR: state <= WB_MEM;
                WB_MEM:  if (pmem_resp) state <= FILL;
                FILL:    state <= RESP;
                default: state <= IDLE;
            endcase
            hit_count  <= cnt_clear ? '0 : (rd_hit && !(&hit_count)) ? hit_count + CNT_W'(1) : hit_count;
            miss_count <= cnt_clear ? '0 : (rd_miss && !(&miss_count)) ? miss_count + CNT_W'(1) : miss_count;
        end
    end

    assign up_resp       = state == RESP;
    assign up_hit        = up_resp & hit_r;
    assign pmem_read     = state == RD_MEM;
    assign pmem_write    = state == WB_MEM;
    assign load_index    = state == WB_ADDR;
    assign VC_write      = load_index | pmem_write;
    assign wb_index_in   = load_index ? v : 3'd0;
    assign L2_read       = rd_hit;
    assign read_index    = rd_hit ? hit_way : 3'd0;
    assign load_VC       = wr_hit | fill;
    assign load_VC_dirty = wr_hit | fill;
    assign load_LRU      = rd_hit | wr_hit | fill;
    // a write hit must not clean a line that is already dirty in the VC
    assign VC_dirty_bit  = wr_hit ? (up_dirty | VC_hit_dirty) : (fill & up_dirty);
    assign write_index   = wr_hit ? hit_way : fill ? v : 3'd0;
endmodule

// File: tb/tb_vc_control.sv
// tb_vc_control: randomized transaction-level check of vc_control against per-cycle expected outputs.
module tb_vc_control;
    localparam int W   = 8;
    localparam int MAX = (1 << W) - 1;

    typedef struct packed {
        logic up_resp, up_hit, pmem_read, pmem_write, load_VC, load_VC_dirty, load_LRU, L2_read, VC_dirty_bit, VC_write, load_index;
        logic [2:0] read_index, write_index, wb_index_in;
    } out_t;

    typedef struct packed {
        logic up_read, up_write, up_dirty, pmem_resp, VC_hit, VC_hit_dirty, cnt_clear;
        logic [2:0] hit_way;
        logic [23:0] LRU_out;
        logic [7:0] dirty_bits;
    } in_t;

    logic clk = 0, rst_n;
    logic up_read, up_write, up_dirty, up_resp, up_hit, pmem_read, pmem_write, pmem_resp;
    logic VC_hit, VC_hit_dirty, cnt_clear;
    logic [2:0] hit_way, read_index, write_index, wb_index_in;
    logic [23:0] LRU_out;
    logic [7:0] dirty_bits;
    logic load_VC, load_VC_dirty, load_LRU, L2_read, VC_dirty_bit, VC_write, load_index;
    logic [W-1:0] hit_count, miss_count;

    vc_control #(.CNT_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .up_read(up_read), .up_write(up_write), .up_dirty(up_dirty),
        .up_resp(up_resp), .up_hit(up_hit), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_resp(pmem_resp), .VC_hit(VC_hit), .VC_hit_dirty(VC_hit_dirty), .hit_way(hit_way),
        .LRU_out(LRU_out), .dirty_bits(dirty_bits), .load_VC(load_VC), .load_VC_dirty(load_VC_dirty),
        .load_LRU(load_LRU), .L2_read(L2_read), .VC_dirty_bit(VC_dirty_bit), .VC_write(VC_write),
        .load_index(load_index), .read_index(read_index), .write_index(write_index),
        .wb_index_in(wb_index_in), .cnt_clear(cnt_clear), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    out_t act;
    assign act = {up_resp, up_hit, pmem_read, pmem_write, load_VC, load_VC_dirty, load_LRU, L2_read,
                  VC_dirty_bit, VC_write, load_index, read_index, write_index, wb_index_in};

    out_t exp_o;
    logic exp_v = 0;
    int exp_hits = 0, exp_miss = 0, exp_lat = 0, exp_hc = -1;
    int cyc_n = 0, start_cyc = 0;
    int n_chk = 0, n_fail = 0;
    logic clr_en = 0, force_clr = 0;

    always @(negedge clk) if (exp_v) begin
        n_chk++;
        if (act !== exp_o) begin
            n_fail++;
            $display("FAIL outs cyc %0d: got %h want %h", cyc_n, act, exp_o);
        end
        n_chk++;
        if (hit_count !== W'(exp_hits) || miss_count !== W'(exp_miss)) begin
            n_fail++;
            $display("FAIL counters cyc %0d: got hit %0d miss %0d want hit %0d miss %0d", cyc_n, hit_count, miss_count, exp_hits, exp_miss);
        end
        if (exp_lat > 0) begin
            n_chk++;
            if (up_resp !== 1'b1 || cyc_n - start_cyc + 1 != exp_lat) begin
                n_fail++;
                $display("FAIL latency cyc %0d: got up_resp %b at %0d want up_resp 1 at %0d", cyc_n, up_resp, cyc_n - start_cyc + 1, exp_lat);
            end
        end
        if (exp_hc >= 0) begin
            n_chk++;
            if (hit_count !== W'(exp_hc)) begin
                n_fail++;
                $display("FAIL hit_count_literal cyc %0d: got %0d want %0d", cyc_n, hit_count, exp_hc);
            end
        end
    end

    function automatic in_t noise();
        in_t r = '0;
        r.pmem_resp    = 1'($urandom);
        r.VC_hit       = 1'($urandom);
        r.VC_hit_dirty = 1'($urandom);
        r.hit_way      = 3'($urandom);
        r.LRU_out      = 24'($urandom);
        r.dirty_bits   = 8'($urandom);
        r.cnt_clear    = clr_en && $urandom_range(0, 19) == 0;
        return r;
    endfunction

    function automatic in_t req(logic rd, logic d);
        in_t r = noise();
        r.up_read  = rd;
        r.up_write = !rd;
        r.up_dirty = d;
        return r;
    endfunction

    task automatic cyc(input in_t i, input out_t o, input int inc, input int lat, input int hc);
        {up_read, up_write, up_dirty, pmem_resp, VC_hit, VC_hit_dirty, cnt_clear, hit_way, LRU_out, dirty_bits} = i;
        exp_o = o; exp_v = 1; exp_lat = lat; exp_hc = hc;
        @(posedge clk);
        cyc_n++;
        if (!rst_n) begin exp_hits = 0; exp_miss = 0; end
        else if (i.cnt_clear) begin exp_hits = 0; exp_miss = 0; end
        else if (inc == 1 && exp_hits < MAX) exp_hits++;
        else if (inc == 2 && exp_miss < MAX) exp_miss++;
        #1;
    endtask

    // kind: 0 read hit, 1 read miss, 2 write hit, 3 write miss (x = victim dirty); x is VC_hit_dirty for write hits
    task automatic txn(input int kind, input logic [2:0] w, input int n, input logic d, input logic x, input int lat_w, input int hc_w);
        in_t i; out_t o; int inc = 0;
        logic rd = kind < 2;
        start_cyc = cyc_n;
        cyc(req(rd, d), '0, 0, 0, -1);
        i = req(rd, d); o = '0;
        i.cnt_clear = i.cnt_clear | force_clr;
        case (kind)
            0: begin i.VC_hit = 1; i.hit_way = w; o.L2_read = 1; o.read_index = w; o.load_LRU = 1; inc = 1; end
            1: begin i.VC_hit = 0; inc = 2; end
            2: begin i.VC_hit = 1; i.hit_way = w; i.VC_hit_dirty = x; o.write_index = w; o.load_VC = 1;
                     o.load_VC_dirty = 1; o.VC_dirty_bit = d | x; o.load_LRU = 1; end
            default: begin i.VC_hit = 0; i.LRU_out[2:0] = w; i.dirty_bits[w] = x; end
        endcase
        cyc(i, o, inc, 0, -1);
        if (kind == 1) for (int k = 0; k < n; k++) begin
            i = req(rd, d); i.pmem_resp = k == n - 1; o = '0; o.pmem_read = 1;
            cyc(i, o, 0, 0, -1);
        end
        if (kind == 3) begin
            if (x) begin
                o = '0; o.wb_index_in = w; o.load_index = 1; o.VC_write = 1;
                cyc(req(rd, d), o, 0, 0, -1);
                for (int k = 0; k < n; k++) begin
                    i = req(rd, d); i.pmem_resp = k == n - 1; o = '0; o.VC_write = 1; o.pmem_write = 1;
                    cyc(i, o, 0, 0, -1);
                end
            end
            o = '0; o.write_index = w; o.load_VC = 1; o.load_VC_dirty = 1; o.VC_dirty_bit = d; o.load_LRU = 1;
            cyc(req(rd, d), o, 0, 0, -1);
        end
        o = '0; o.up_resp = 1; o.up_hit = kind == 0;
        cyc(req(rd, d), o, 0, lat_w, hc_w);
    endtask

    task automatic gap(input int n);
        in_t i;
        for (int k = 0; k < n; k++) begin
            i = noise(); i.up_read = 0; i.up_write = 0;
            cyc(i, '0, 0, 0, -1);
        end
    endtask

    initial begin
        in_t i; out_t o;
        int kind, n, lat;
        rst_n = 0;
        {up_read, up_write, up_dirty, pmem_resp, VC_hit, VC_hit_dirty, cnt_clear, hit_way, LRU_out, dirty_bits} = '0;
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) cyc(req(1, 0), '0, 0, 0, 0);
        rst_n = 1;
        txn(1, 0, 3, 0, 0, 6, 0);
        gap(1);
        txn(0, 5, 0, 0, 0, 3, 1);
        txn(1, 0, 4, 0, 0, 7, 1);
        gap(2);
        txn(3, 3, 2, 1, 1, 7, 1);
        txn(3, 3, 2, 0, 1, 7, 1);
        txn(2, 6, 0, 0, 1, 3, 1);
        txn(3, 4, 0, 1, 0, 4, 1);
        gap(1);
        // asynchronous reset while RD_MEM holds pmem_read
        cyc(req(1, 0), '0, 0, 0, -1);
        i = req(1, 0); i.VC_hit = 0;
        cyc(i, '0, 2, 0, -1);
        i = req(1, 0); i.pmem_resp = 0; o = '0; o.pmem_read = 1;
        cyc(i, o, 0, 0, -1);
        #1 rst_n = 0; exp_hits = 0; exp_miss = 0;
        cyc(req(1, 0), '0, 0, 0, 0);
        cyc(req(1, 0), '0, 0, 0, 0);
        rst_n = 1;
        txn(0, 2, 0, 0, 0, 3, 1);
        // saturation on a narrow counter
        for (int k = 0; k < MAX - 2; k++) txn(0, 3'($urandom), 0, 0, 0, 3, -1);
        txn(0, 1, 0, 0, 0, 3, MAX);
        txn(0, 7, 0, 0, 0, 3, MAX);
        force_clr = 1;
        txn(0, 4, 0, 0, 0, 3, 0);
        force_clr = 0;
        txn(0, 4, 0, 0, 0, 3, 1);
        clr_en = 1;
        for (int t = 0; t < 300; t++) begin
            kind = $urandom_range(0, 3);
            n = $urandom_range(1, 4);
            i = noise();
            lat = kind == 1 ? 3 + n : (kind == 3 ? (i.VC_hit_dirty ? 5 + n : 4) : 3);
            txn(kind, i.hit_way, n, i.up_dirty ^ i.pmem_resp, i.VC_hit_dirty, lat, -1);
            gap($urandom_range(0, 2));
        end
        exp_v = 0;
        #20;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
